// File: rtl/pipe_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_reg_pkg
// Shared definitions for the handshaked pipeline stage register.
//   pipe_state_t : control state; its 2-bit encoding equals the occupancy.
//   OCC_W        : occupancy output width.
//   DATA_W_MIN/MAX and data_w_legal(): legal payload width range.
// -----------------------------------------------------------------------------
package pipe_reg_pkg;

   localparam int OCC_W      = 2;
   localparam int DATA_W_MIN = 1;
   localparam int DATA_W_MAX = 512;

   typedef logic [OCC_W-1:0] pipe_state_t;

   // Encoding doubles as the number of held entries.
   localparam pipe_state_t ST_EMPTY = 2'd0;
   localparam pipe_state_t ST_FULL  = 2'd1;
   localparam pipe_state_t ST_SKID  = 2'd2;

   function automatic bit data_w_legal(input int w);
      return (w >= DATA_W_MIN) && (w <= DATA_W_MAX);
   endfunction

endpackage : pipe_reg_pkg

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
// Bundles the upstream/downstream handshake, payload and control signals of
// one pipeline stage boundary.
//   slave  : view taken by pipe_stage_reg itself.
//   master : view taken by whatever drives the stage (surrounding pipeline).
// Signals:
//   valid/data_pipe_reg_i, ready_pipe_reg_o : upstream side
//   valid/data_pipe_reg_o, ready_pipe_reg_i : downstream side
//   flush/stall_pipe_reg_i                  : stage control
//   instr_retired_pipe_reg_o                : output-transfer pulse
//   occupancy_pipe_reg_o                    : held entries, 0..2
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if
   import pipe_reg_pkg::*;
#(
   parameter int DATA_W = 64
);

   logic              valid_pipe_reg_i;
   logic              ready_pipe_reg_o;
   logic [DATA_W-1:0] data_pipe_reg_i;
   logic              flush_pipe_reg_i;
   logic              stall_pipe_reg_i;
   logic              valid_pipe_reg_o;
   logic              ready_pipe_reg_i;
   logic [DATA_W-1:0] data_pipe_reg_o;
   logic              instr_retired_pipe_reg_o;
   logic [OCC_W-1:0]  occupancy_pipe_reg_o;

   modport slave (
      input  valid_pipe_reg_i, data_pipe_reg_i, flush_pipe_reg_i,
             stall_pipe_reg_i, ready_pipe_reg_i,
      output ready_pipe_reg_o, valid_pipe_reg_o, data_pipe_reg_o,
             instr_retired_pipe_reg_o, occupancy_pipe_reg_o
   );

   modport master (
      output valid_pipe_reg_i, data_pipe_reg_i, flush_pipe_reg_i,
             stall_pipe_reg_i, ready_pipe_reg_i,
      input  ready_pipe_reg_o, valid_pipe_reg_o, data_pipe_reg_o,
             instr_retired_pipe_reg_o, occupancy_pipe_reg_o
   );

endinterface : pipe_stage_reg_if

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Single DATA_W storage entry with load and clear controls; holds the beat
// accepted while the main entry is blocked downstream.
//   clk, reset_n : clock, asynchronous active-low reset
//   load, d      : capture d on the rising edge
//   clear        : zero the entry (wins over load)
//   q            : stored entry
// -----------------------------------------------------------------------------
module pipe_skid_buf #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (clear) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule : pipe_skid_buf

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Handshaked pipeline register carrying an opaque DATA_W payload between two
// pipeline stages, with stall, flush, a retire pulse and an optional skid
// entry.
//
// Build option:
//   PIPE_REG_SKID_EN  defined   -> skid entry, SKID state, registered ready.
//                     undefined -> EMPTY/FULL only, ready combinational from
//                                  downstream ready and stall.
// Parameters:
//   DATA_W          payload width, 1..512
//   CLEAR_ON_FLUSH  1: flush zeroes payload storage, 0: storage left stale
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      pipe_stage_reg_if.slave (handshake, payload, flush/stall,
//            retire pulse, occupancy)
// -----------------------------------------------------------------------------
module pipe_stage_reg
   import pipe_reg_pkg::*;
#(
   parameter int DATA_W         = 64,
   parameter bit CLEAR_ON_FLUSH = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   pipe_stage_reg_if.slave   bus
);

   if (!data_w_legal(DATA_W)) begin : g_bad_data_w
      $error("pipe_stage_reg: DATA_W out of range");
   end

   pipe_state_t       state_q;
   pipe_state_t       state_d;
   logic [DATA_W-1:0] main_q;
   logic              main_load;
   logic              valid_out;
   logic              ready_out;
   logic              in_fire;
   logic              out_fire;
   logic              clear_store;

`ifdef PIPE_REG_SKID_EN
   logic [DATA_W-1:0] skid_q;
   logic              skid_load;
   logic              main_from_skid;
`endif

   assign valid_out   = (state_q != ST_EMPTY);
   assign out_fire    = valid_out & bus.ready_pipe_reg_i
                      & ~bus.stall_pipe_reg_i & ~bus.flush_pipe_reg_i;
   assign clear_store = bus.flush_pipe_reg_i & CLEAR_ON_FLUSH;

`ifdef PIPE_REG_SKID_EN
   // Decoded from the state flop only, so downstream ready/stall never
   // reach upstream ready combinationally.
   assign ready_out = (state_q != ST_SKID);
`else
   assign ready_out = ~valid_out
                    | (bus.ready_pipe_reg_i & ~bus.stall_pipe_reg_i);
`endif

   // A flushed input still handshakes upstream; its payload is dropped below.
   assign in_fire = bus.valid_pipe_reg_i & ready_out;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      main_load = 1'b0;
`ifdef PIPE_REG_SKID_EN
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
`endif
      if (bus.flush_pipe_reg_i) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d   = ST_FULL;
                  main_load = 1'b1;
               end
            end
            ST_FULL: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
`ifdef PIPE_REG_SKID_EN
                  state_d   = ST_SKID;
                  skid_load = 1'b1;
`endif
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
`ifdef PIPE_REG_SKID_EN
            ST_SKID: begin
               // ready_out is low here, so no input can arrive this cycle.
               if (out_fire) begin
                  state_d        = ST_FULL;
                  main_from_skid = 1'b1;
               end
            end
`endif
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // NOTE: state and payload flops use non-blocking assignments so every
   // flop samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: the payload is reset even though valid gates it, so data_o reads
   // zero out of reset and after a clearing flush.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_q <= '0;
      end else if (clear_store) begin
         main_q <= '0;
      end else if (main_load) begin
         main_q <= bus.data_pipe_reg_i;
`ifdef PIPE_REG_SKID_EN
      end else if (main_from_skid) begin
         main_q <= skid_q;
`endif
      end
   end

`ifdef PIPE_REG_SKID_EN
   pipe_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (skid_load),
      .clear   (clear_store),
      .d       (bus.data_pipe_reg_i),
      .q       (skid_q)
   );
`endif

   assign bus.ready_pipe_reg_o         = ready_out;
   assign bus.valid_pipe_reg_o         = valid_out;
   assign bus.data_pipe_reg_o          = main_q;
   assign bus.instr_retired_pipe_reg_o = out_fire;
`ifdef PIPE_REG_SKID_EN
   assign bus.occupancy_pipe_reg_o     = state_q;
`else
   assign bus.occupancy_pipe_reg_o     = {1'b0, state_q[0]};
`endif

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Scoreboard bench for pipe_stage_reg. The reference model is a FIFO of
// accepted payloads bounded by the stage capacity (1 without skid, 2 with);
// a negedge monitor compares every DUT output against it each cycle.
// Honours PIPE_REG_SKID_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

   localparam int DW = 32;
`ifdef PIPE_REG_SKID_EN
   localparam int  CAP     = 2;
   localparam bit  SKID_EN = 1'b1;
`else
   localparam int  CAP     = 1;
   localparam bit  SKID_EN = 1'b0;
`endif

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   pipe_stage_reg_if #(.DATA_W(DW)) bus ();

   pipe_stage_reg #(
      .DATA_W         (DW),
      .CLEAR_ON_FLUSH (1'b1)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] held_val = '0;
   int            retire_cnt = 0;
   int            max_occ = 0;
   bit            seen_77 = 1'b0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor + reference model. Inputs are stable between posedge+1 and the
   // next posedge, so the negedge sees exactly what the next edge will use.
   always @(negedge clk) begin
      int  sz;
      bit  e_ready, e_out, e_in;
      logic [DW-1:0] e_data;
      if (!reset_n) begin
         check("rst_valid",   bus.valid_pipe_reg_o, 0);
         check("rst_occ",     bus.occupancy_pipe_reg_o, 0);
         check("rst_data",    bus.data_pipe_reg_o, 0);
         check("rst_retired", bus.instr_retired_pipe_reg_o, 0);
         check("rst_ready",   bus.ready_pipe_reg_o, 1);
         exp_q.delete();
         held_val = '0;
      end else begin
         sz      = exp_q.size();
         e_ready = SKID_EN ? (sz < CAP)
                           : (sz == 0 || (bus.ready_pipe_reg_i && !bus.stall_pipe_reg_i));
         e_out   = (sz > 0) && bus.ready_pipe_reg_i && !bus.stall_pipe_reg_i
                   && !bus.flush_pipe_reg_i;
         e_in    = bus.valid_pipe_reg_i && e_ready;
         e_data  = (sz > 0) ? exp_q[0] : held_val;

         check("valid",   bus.valid_pipe_reg_o, (sz > 0));
         check("occ",     bus.occupancy_pipe_reg_o, sz);
         check("ready",   bus.ready_pipe_reg_o, e_ready);
         check("retired", bus.instr_retired_pipe_reg_o, e_out);
         check("data",    bus.data_pipe_reg_o, e_data);

         if (bus.instr_retired_pipe_reg_o) retire_cnt++;
         if (int'(bus.occupancy_pipe_reg_o) > max_occ) max_occ = int'(bus.occupancy_pipe_reg_o);
         if (bus.valid_pipe_reg_o && bus.data_pipe_reg_o == DW'(32'h77)) seen_77 = 1'b1;

         if (bus.flush_pipe_reg_i) begin
            exp_q.delete();
            held_val = '0;
         end else begin
            if (e_out) held_val = exp_q.pop_front();
            if (e_in)  exp_q.push_back(bus.data_pipe_reg_i);
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat and hold it until the stage accepts it.
   task automatic send(input logic [DW-1:0] v);
      bit done = 1'b0;
      bus.valid_pipe_reg_i = 1'b1;
      bus.data_pipe_reg_i  = v;
      for (int k = 0; k < 64 && !done; k++) begin
         @(negedge clk);
         done = bus.ready_pipe_reg_o;
         @(posedge clk);
         #1;
      end
      check("send_accept", done, 1);
      bus.valid_pipe_reg_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.valid_pipe_reg_i = 1'b1;
      bus.data_pipe_reg_i  = DW'(32'hA5);
      bus.flush_pipe_reg_i = 1'b0;
      bus.stall_pipe_reg_i = 1'b0;
      bus.ready_pipe_reg_i = 1'b1;

      // Reset held with a valid input pending; release just after an edge.
      repeat (3) cycle();
      reset_n = 1'b1;
      cycle();
      bus.valid_pipe_reg_i = 1'b0;
      @(negedge clk);
      check("post_reset_valid", bus.valid_pipe_reg_o, 1);
      check("post_reset_data",  bus.data_pipe_reg_o, 32'hA5);
      repeat (3) cycle();

      // Streaming: 8 back-to-back beats.
      retire_cnt = 0;
      for (int i = 1; i <= 8; i++) send(DW'(i));
      repeat (3) cycle();
      check("stream_retires", retire_cnt, 8);

      // Backpressure: downstream blocked while 1,2,3 are offered.
      max_occ = 0;
      bus.ready_pipe_reg_i = 1'b0;
      fork
         begin send(DW'(1)); send(DW'(2)); send(DW'(3)); end
         begin repeat (5) @(posedge clk); #1; bus.ready_pipe_reg_i = 1'b1; end
      join
      repeat (4) cycle();
      check("bp_max_occ", max_occ, CAP);

      // Flush with a same-cycle 0x77 input while the stage is full.
      seen_77 = 1'b0;
      bus.ready_pipe_reg_i = 1'b0;
      send(DW'(32'h11));
`ifdef PIPE_REG_SKID_EN
      send(DW'(32'h22));
`endif
      bus.valid_pipe_reg_i = 1'b1;
      bus.data_pipe_reg_i  = DW'(32'h77);
      bus.flush_pipe_reg_i = 1'b1;
      cycle();
      bus.flush_pipe_reg_i = 1'b0;
      bus.valid_pipe_reg_i = 1'b0;
      @(negedge clk);
      check("flush_valid", bus.valid_pipe_reg_o, 0);
      check("flush_occ",   bus.occupancy_pipe_reg_o, 0);
      check("flush_data",  bus.data_pipe_reg_o, 0);
      bus.ready_pipe_reg_i = 1'b1;
      repeat (3) cycle();
      check("no_0x77", seen_77, 0);

      // Stall with downstream ready for 3 cycles, then release.
      bus.stall_pipe_reg_i = 1'b1;
      send(DW'(32'h33));
      retire_cnt = 0;
      repeat (3) cycle();
      check("stall_no_retire", retire_cnt, 0);
      bus.stall_pipe_reg_i = 1'b0;
      repeat (3) cycle();
      check("stall_release_retire", retire_cnt, 1);

      // Asynchronous reset in mid-cycle with traffic in flight.
      bus.ready_pipe_reg_i = 1'b0;
      send(DW'(32'h44));
      bus.valid_pipe_reg_i = 1'b1;
      bus.data_pipe_reg_i  = DW'(32'h55);
      #2;
      reset_n = 1'b0;
      cycle();
      cycle();
      reset_n = 1'b1;
      bus.valid_pipe_reg_i = 1'b0;
      bus.ready_pipe_reg_i = 1'b1;
      repeat (2) cycle();

      // Randomised traffic; inputs change freely regardless of ready.
      for (int i = 0; i < 400; i++) begin
         bus.valid_pipe_reg_i = ($urandom_range(0, 3) != 0);
         bus.data_pipe_reg_i  = DW'($urandom);
         bus.ready_pipe_reg_i = ($urandom_range(0, 3) != 0);
         bus.stall_pipe_reg_i = ($urandom_range(0, 9) == 0);
         bus.flush_pipe_reg_i = ($urandom_range(0, 31) == 0);
         cycle();
      end

      bus.valid_pipe_reg_i = 1'b0;
      bus.ready_pipe_reg_i = 1'b1;
      bus.stall_pipe_reg_i = 1'b0;
      bus.flush_pipe_reg_i = 1'b0;
      repeat (4) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pipe_stage_reg
